// File: rtl/keycode_pkg.sv
// Shared constants and types for the keycode event queue.
package keycode_pkg;

  localparam int KEY_W_DEF = 8;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  typedef enum logic [1:0] {IDLE, REL, PRS, COMMIT} scan_state_t;

  typedef struct packed {
    logic                 press;
    logic [KEY_W_DEF-1:0] code;
  } key_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead event FIFO with sticky overflow; a push on a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   clear_overflow,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != FULL) || do_pop);
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // clear wins over a drop in the same cycle
      if (clear_overflow)
        overflow <= 1'b0;
      else if (push && !do_push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Diffs each HID report against the previous one and queues release events
// (slot order) followed by press events (slot order).
//   state  | meaning
//   IDLE   | waiting for a pending or strobed report
//   REL    | slot idx of prev checked for release
//   PRS    | slot idx of cur checked for press
//   COMMIT | prev <= cur
module keycode_event_queue
  import keycode_pkg::*;
#(
  parameter int NUM_KEYS = 6,
  parameter int KEY_W    = 8,
  parameter int DEPTH    = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_KEYS*KEY_W-1:0] keycodes_in,
  input  logic                      report_strobe,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [KEY_W-1:0]          evt_code,
  output logic                      evt_press,
  output logic [$clog2(DEPTH):0]    evt_count,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic                      busy
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
  localparam logic [KEY_W-1:0] K_NONE   = KEY_W'(KEY_NONE);
  localparam logic [KEY_W-1:0] K_ROLL   = KEY_W'(KEY_ROLLOVER);

  scan_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [KEY_W-1:0] prev_r [NUM_KEYS];
  logic [KEY_W-1:0] cur_r  [NUM_KEYS];
  logic [KEY_W-1:0] pend_r [NUM_KEYS];
  logic [KEY_W-1:0] in_key [NUM_KEYS];
  logic             pend_flag;
  logic             is_rollover, accept;
  logic             load_cur, commit, evt_push;
  logic [KEY_W-1:0] scan_key;
  logic             in_other, in_prefix;
  logic [KEY_W:0]   head_data;

  always_comb begin
    is_rollover = 1'b1;
    for (int i = 0; i < NUM_KEYS; i++) begin
      in_key[i] = keycodes_in[i*KEY_W +: KEY_W];
      if (in_key[i] != K_ROLL) is_rollover = 1'b0;
    end
  end

  // rollover-error reports are dropped at the door so they never reach pending
  assign accept = report_strobe && !is_rollover;

  // membership: key against the other report, and against earlier slots of its own
  always_comb begin
    scan_key  = (state == PRS) ? cur_r[idx] : prev_r[idx];
    in_other  = 1'b0;
    in_prefix = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (state == PRS) begin
        if (prev_r[i] == scan_key) in_other = 1'b1;
        if (IDX_W'(i) < idx && cur_r[i] == scan_key) in_prefix = 1'b1;
      end else begin
        if (cur_r[i] == scan_key) in_other = 1'b1;
        if (IDX_W'(i) < idx && prev_r[i] == scan_key) in_prefix = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_cur  = 1'b0;
    commit    = 1'b0;
    evt_push  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_flag || accept) begin
          load_cur  = 1'b1;
          idx_nxt   = '0;
          state_nxt = REL;
        end
      end
      REL, PRS: begin
        evt_push = (scan_key != K_NONE) && !in_other && !in_prefix;
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = (state == REL) ? PRS : COMMIT;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_flag <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        prev_r[i] <= K_NONE;
        cur_r[i]  <= K_NONE;
        pend_r[i] <= K_NONE;
      end
    end else begin
      // last strobe wins while a scan is running or another report waits
      if (accept && (state != IDLE || pend_flag))
        pend_flag <= 1'b1;
      else if (load_cur)
        pend_flag <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (accept && (state != IDLE || pend_flag)) pend_r[i] <= in_key[i];
        if (load_cur) cur_r[i] <= pend_flag ? pend_r[i] : in_key[i];
        if (commit)   prev_r[i] <= cur_r[i];
      end
    end
  end

  sync_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (Clk),
    .rst            (Reset),
    .push           (evt_push),
    .push_data      ({state == PRS, scan_key}),
    .pop            (evt_ready),
    .clear_overflow (clear_overflow),
    .head_valid     (evt_valid),
    .head_data      (head_data),
    .count          (evt_count),
    .overflow       (overflow)
  );

  assign evt_press = head_data[KEY_W];
  assign evt_code  = head_data[KEY_W-1:0];
  assign busy      = (state != IDLE) || pend_flag;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: fixed vectors, corner sequences and random
// reports checked against a set-difference reference model.
module tb_keycode_event_queue;
  import keycode_pkg::*;

  localparam int N  = 6;
  localparam int KW = 8;
  localparam int D  = 16;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [N*KW-1:0] keycodes_in;
  logic            report_strobe;
  logic            evt_valid;
  logic            evt_ready;
  logic [KW-1:0]   evt_code;
  logic            evt_press;
  logic [4:0]      evt_count;
  logic            overflow;
  logic            clear_overflow;
  logic            busy;

  keycode_event_queue #(.NUM_KEYS(N), .KEY_W(KW), .DEPTH(D)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .keycodes_in    (keycodes_in),
    .report_strobe  (report_strobe),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_press      (evt_press),
    .evt_count      (evt_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .busy           (busy)
  );

  always #5 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  key_evt_t    exp_q[$];
  logic [47:0] model_prev;

  typedef struct {
    logic [47:0]     report;
    int              len;
    int              n;
    logic [1:0][8:0] ev;
  } vec_t;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_head(input string name);
    key_evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event code=%0h press=%0b, none expected", name, evt_code, evt_press);
    end else begin
      e = exp_q.pop_front();
      if (!(evt_valid === 1'b1 && evt_code === e.code && evt_press === e.press)) begin
        errors++;
        $display("FAIL %s: got valid=%0b code=%0h press=%0b expected code=%0h press=%0b",
                 name, evt_valid, evt_code, evt_press, e.code, e.press);
      end
    end
  endtask

  task automatic pop_check(input string name);
    evt_ready = 1'b1;
    cmp_head(name);
    step();
    evt_ready = 1'b0;
  endtask

  function automatic logic [47:0] mk(input logic [7:0] s0, s1, s2, s3, s4, s5);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  function automatic bit has(input logic [7:0] q[$], input logic [7:0] k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // releases = distinct old keys missing from the new report, then presses =
  // distinct new keys missing from the old one; each in first-appearance order
  function automatic void model_report(input logic [47:0] cur);
    logic [7:0] p[$], c[$], seen[$];
    bit roll = 1'b1;
    for (int i = 0; i < N; i++) begin
      p.push_back(model_prev[i*8 +: 8]);
      c.push_back(cur[i*8 +: 8]);
      if (cur[i*8 +: 8] != 8'h01) roll = 1'b0;
    end
    if (roll) return;
    foreach (p[i]) if (p[i] != 8'h00 && !has(seen, p[i])) begin
      seen.push_back(p[i]);
      if (!has(c, p[i])) exp_q.push_back('{press: 1'b0, code: p[i]});
    end
    seen.delete();
    foreach (c[i]) if (c[i] != 8'h00 && !has(seen, c[i])) begin
      seen.push_back(c[i]);
      if (!has(p, c[i])) exp_q.push_back('{press: 1'b1, code: c[i]});
    end
    model_prev = cur;
  endfunction

  task automatic send_report(input logic [47:0] r, output int first_valid, output int done_k);
    keycodes_in   = r;
    report_strobe = 1'b1;
    first_valid   = -1;
    done_k        = -1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0 && !busy) begin
        done_k = k;
        break;
      end
      if (evt_valid && first_valid < 0) first_valid = k;
      step();
      report_strobe = 1'b0;
    end
    report_strobe = 1'b0;
    check("scan_done", 32'(done_k >= 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    int          fv, dk, low_k, busy_cnt, cnt;
    logic [47:0] r1, r2, r3, r, ra, rb;
    logic [7:0]  pool[8];
    bit          done;

    keycodes_in    = '0;
    report_strobe  = 1'b0;
    evt_ready      = 1'b0;
    clear_overflow = 1'b0;
    Reset          = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_code",  32'(evt_code), 0);
    check("rst_evt_press", 32'(evt_press), 0);
    check("rst_evt_count", 32'(evt_count), 0);
    check("rst_overflow",  32'(overflow), 0);
    check("rst_busy",      32'(busy), 0);
    Reset = 1'b0;
    step();

    vecs[0] = '{report: mk(8'h04, 0, 0, 0, 0, 0),  len: 14, n: 1, ev: {9'h000, 9'h104}};
    vecs[1] = '{report: mk(8'h16, 8'h04, 0, 0, 0, 0), len: 14, n: 1, ev: {9'h000, 9'h116}};
    vecs[2] = '{report: 48'h0,                   len: 14, n: 2, ev: {9'h004, 9'h016}};
    vecs[3] = '{report: mk(8'h1A, 8'h1A, 0, 0, 0, 0), len: 14, n: 1, ev: {9'h000, 9'h11A}};
    vecs[4] = '{report: 48'h010101010101,        len: 1,  n: 0, ev: {9'h000, 9'h000}};
    vecs[5] = '{report: 48'h0,                   len: 14, n: 1, ev: {9'h000, 9'h01A}};

    for (int v = 0; v < 6; v++) begin
      send_report(vecs[v].report, fv, dk);
      check($sformatf("vec%0d_scan_len", v), 32'(dk), 32'(vecs[v].len));
      if (v == 0) check("vec0_first_valid_cycle", 32'(fv), N + 2);
      check($sformatf("vec%0d_count", v), 32'(evt_count), 32'(vecs[v].n));
      for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(key_evt_t'(vecs[v].ev[j]));
      for (int j = 0; j < vecs[v].n; j++) pop_check($sformatf("vec%0d_evt%0d", v, j));
      check($sformatf("vec%0d_empty", v), 32'(evt_valid), 0);
    end

    // overflow: 6 presses + 6 releases + 6 presses into 16 entries
    ra = mk(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15);
    rb = mk(8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25);
    send_report(ra, fv, dk);
    send_report(48'h0, fv, dk);
    send_report(rb, fv, dk);
    check("ovf_count", 32'(evt_count), D);
    check("ovf_set", 32'(overflow), 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    exp_q.delete();
    for (int j = 0; j < 6; j++) exp_q.push_back('{press: 1'b1, code: 8'h10 + 8'(j)});
    for (int j = 0; j < 6; j++) exp_q.push_back('{press: 1'b0, code: 8'h10 + 8'(j)});
    for (int j = 0; j < 4; j++) exp_q.push_back('{press: 1'b1, code: 8'h20 + 8'(j)});
    for (int j = 0; j < 6; j++) exp_q.push_back('{press: 1'b0, code: 8'h20 + 8'(j)});

    // releases pushed into a full FIFO while popping every cycle
    keycodes_in   = '0;
    report_strobe = 1'b1;
    step();
    report_strobe = 1'b0;
    for (int j = 0; j < 6; j++) pop_check($sformatf("full_pushpop%0d", j));
    check("full_pushpop_count", 32'(evt_count), D);
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("full_scan_done", 32'(done), 1);
    check("full_no_ovf", 32'(overflow), 0);
    for (int j = 0; j < 16; j++) pop_check($sformatf("full_drain%0d", j));
    check("full_empty", 32'(evt_valid), 0);

    // three strobes during a scan: only first and last are diffed
    r1 = mk(8'h04, 8'h05, 0, 0, 0, 0);
    r2 = mk(8'h06, 0, 0, 0, 0, 0);
    r3 = mk(8'h05, 8'h07, 0, 0, 0, 0);
    exp_q.delete();
    model_prev = 48'h0;
    model_report(r1);
    model_report(r3);
    low_k = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      report_strobe = (k == 0 || k == 2 || k == 4);
      keycodes_in   = (k == 0) ? r1 : (k == 2) ? r2 : r3;
      if (k > 0 && !busy && low_k < 0) low_k = k;
      if (k > 0 && k < 28 && busy) busy_cnt++;
      step();
    end
    report_strobe = 1'b0;
    check("pend_busy_low_cycle", 32'(low_k), 28);
    check("pend_busy_cycles", 32'(busy_cnt), 27);
    check("pend_count", 32'(evt_count), 4);
    cnt = exp_q.size();
    for (int j = 0; j < cnt; j++) pop_check($sformatf("pend_evt%0d", j));
    check("pend_empty", 32'(evt_valid), 0);

    // reset in the middle of PRS with three presses queued
    r = mk(8'h05, 8'h07, 8'h30, 8'h31, 8'h32, 0);
    keycodes_in   = r;
    report_strobe = 1'b1;
    step();
    report_strobe = 1'b0;
    repeat (11) step();
    check("midrst_pre_count", 32'(evt_count), 3);
    check("midrst_pre_busy", 32'(busy), 1);
    Reset = 1'b1;
    #1;
    check("midrst_valid", 32'(evt_valid), 0);
    check("midrst_count", 32'(evt_count), 0);
    check("midrst_busy", 32'(busy), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step();
    exp_q.delete();
    model_prev = 48'h0;
    model_report(r);
    send_report(r, fv, dk);
    check("midrst_resend_count", 32'(evt_count), 5);
    for (int j = 0; j < 5; j++) pop_check($sformatf("midrst_evt%0d", j));

    // random reports with random back-pressure against the model
    pool = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    for (int rnd = 0; rnd < 30; rnd++) begin
      if ($urandom_range(0, 9) == 0) r = 48'h010101010101;
      else for (int i = 0; i < N; i++) r[i*8 +: 8] = pool[$urandom_range(0, 7)];
      model_report(r);
      keycodes_in   = r;
      report_strobe = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (k > 0 && !busy) begin
          done = 1'b1;
          break;
        end
        evt_ready = 1'($urandom_range(0, 1));
        if (evt_valid && evt_ready) cmp_head($sformatf("rand%0d_evt", rnd));
        step();
        report_strobe = 1'b0;
        evt_ready     = 1'b0;
      end
      check($sformatf("rand%0d_done", rnd), 32'(done), 1);
      for (int j = 0; j < 20 && exp_q.size() > 0; j++) pop_check($sformatf("rand%0d_drain", rnd));
      check($sformatf("rand%0d_empty", rnd), 32'(evt_valid), 0);
    end
    check("rand_no_ovf", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
